// File: rtl/fpu_seq_mul_if.sv
// Operand/result bundle for the sequential multiplier; level start/done
// handshake shared with the FPU's sequential divider.
interface fpu_seq_mul_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               start_operation_mul_fsm;
    logic [2*WIDTH-1:0] product;
    logic               operation_done_mul_fsm;
    logic               busy;

    // Handshake: the requester raises start with stable operands; the unit
    // samples them on the edge it leaves idle and raises done when the product
    // is valid. Done holds while start stays high and falls one edge after
    // start drops. A new operation needs start to go low and high again.
    modport master (
        output multiplicand, multiplier, start_operation_mul_fsm,
        input  product, operation_done_mul_fsm, busy
    );

    modport slave (
        input  multiplicand, multiplier, start_operation_mul_fsm,
        output product, operation_done_mul_fsm, busy
    );
endinterface

// File: rtl/fpu_seq_mul.sv
// Unsigned shift-and-add multiplier, one multiplier bit per iteration.
// Product is 2*WIDTH bits and is held until the next completion or reset.
module fpu_seq_mul #(
    parameter int WIDTH = 24
) (
    input  logic            clk,
    input  logic            arst,
    fpu_seq_mul_if.slave    mul_if,
    output logic [2:0]      dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        MUL_IDLE_ST          = 3'd0,
        MUL_START_ST         = 3'd1,
        MUL_TEST_ST          = 3'd2,
        MUL_ADD_ST           = 3'd3,
        MUL_SHIFT_ST         = 3'd4,
        MUL_CHECK_COUNTER_ST = 3'd5,
        MUL_RESULT_VALID_ST  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   mq_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               done_q;
    logic               busy_q;

    always_comb begin
        state_d = MUL_IDLE_ST;
        case (state_q)
            MUL_IDLE_ST:          state_d = mul_if.start_operation_mul_fsm ? MUL_START_ST : MUL_IDLE_ST;
            MUL_START_ST:         state_d = MUL_TEST_ST;
            MUL_TEST_ST:          state_d = mq_q[0] ? MUL_ADD_ST : MUL_SHIFT_ST;
            MUL_ADD_ST:           state_d = MUL_SHIFT_ST;
            MUL_SHIFT_ST:         state_d = MUL_CHECK_COUNTER_ST;
            MUL_CHECK_COUNTER_ST: state_d = (cnt_q == '0) ? MUL_RESULT_VALID_ST : MUL_TEST_ST;
            MUL_RESULT_VALID_ST:  state_d = mul_if.start_operation_mul_fsm ? MUL_RESULT_VALID_ST
                                                                           : MUL_IDLE_ST;
            default:              state_d = MUL_IDLE_ST;
        endcase
    end

    // done/busy are registered from the next state so they move with state_q.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= MUL_IDLE_ST;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == MUL_RESULT_VALID_ST);
            busy_q  <= (state_d != MUL_IDLE_ST) && (state_d != MUL_RESULT_VALID_ST);
            case (state_q)
                MUL_IDLE_ST: begin
                    // Operands are captured on the edge entering the start state.
                    if (mul_if.start_operation_mul_fsm) begin
                        mcand_q <= mul_if.multiplicand;
                        mq_q    <= mul_if.multiplier;
                        acc_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                    end
                end
                MUL_ADD_ST: begin
                    acc_q <= {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q};
                end
                MUL_SHIFT_ST: begin
                    acc_q <= {1'b0, acc_q[WIDTH:1]};
                    mq_q  <= {acc_q[0], mq_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - 1'b1;
                end
                MUL_CHECK_COUNTER_ST: begin
                    if (cnt_q == '0) begin
                        product_q <= {acc_q[WIDTH-1:0], mq_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_if.product                = product_q;
    assign mul_if.operation_done_mul_fsm = done_q;
    assign mul_if.busy                   = busy_q;
    assign dbg_state_o                   = state_q;

endmodule

// File: tb/tb_fpu_seq_mul.sv
// Directed bench for fpu_seq_mul: expected products queued at launch and
// compared at completion, with latency, busy and handshake checks.
module tb_fpu_seq_mul;

    localparam int W = 24;

    logic       clk;
    logic       arst;
    logic [2:0] dbg_state;

    int total;
    int bad;

    logic [2*W-1:0] exp_q[$];

    fpu_seq_mul_if #(.WIDTH(W)) mif ();

    fpu_seq_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .arst        (arst),
        .mul_if      (mif),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit pulse, input bit scramble, input int hold);
        int             cyc;
        int             lat;
        bit             seen;
        logic [2*W-1:0] exp_p;
        @(negedge clk);
        mif.multiplicand            = a;
        mif.multiplier              = b;
        mif.start_operation_mul_fsm = 1'b1;
        exp_q.push_back((2*W)'(a) * (2*W)'(b));
        lat  = 2 + 3*W + $countones(b);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4*W + 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pulse) mif.start_operation_mul_fsm = 1'b0;
            if (scramble) begin
                mif.multiplicand = W'($urandom_range(0, (1 << W) - 1));
                mif.multiplier   = W'($urandom_range(0, (1 << W) - 1));
            end
            if (mif.operation_done_mul_fsm === 1'b1) seen = 1'b1;
            else check("busy_mid_op", 64'(mif.busy), 64'(1));
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(cyc), 64'(lat));
        check("scoreboard_depth", 64'(exp_q.size()), 64'(1));
        exp_p = '0;
        if (exp_q.size() != 0) exp_p = exp_q.pop_front();
        check("product", 64'(mif.product), 64'(exp_p));
        check("busy_at_done", 64'(mif.busy), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("done_hold", 64'(mif.operation_done_mul_fsm), 64'(1));
            check("busy_hold", 64'(mif.busy), 64'(0));
            check("product_hold", 64'(mif.product), 64'(exp_p));
        end
        mif.start_operation_mul_fsm = 1'b0;
        @(posedge clk);
        #1;
        check("done_fall", 64'(mif.operation_done_mul_fsm), 64'(0));
        check("busy_idle", 64'(mif.busy), 64'(0));
        check("product_kept", 64'(mif.product), 64'(exp_p));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mif.multiplicand            = '0;
        mif.multiplier              = '0;
        mif.start_operation_mul_fsm = 1'b0;
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_product", 64'(mif.product), 64'(0));
        check("rst_done", 64'(mif.operation_done_mul_fsm), 64'(0));
        check("rst_busy", 64'(mif.busy), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        arst = 1'b0;

        // Basic product, start held 10 cycles past done.
        run_op(24'd3, 24'd5, 1'b0, 1'b0, 10);
        // Maximum operands, start dropped right after done.
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 0);
        // Zero multiplier with a one-cycle start pulse.
        run_op(24'h123456, 24'h000000, 1'b1, 1'b0, 0);
        run_op(24'h800000, 24'h000002, 1'b0, 1'b0, 3);
        // Operands change every cycle after the load edge.
        run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
               1'b0, 1'b1, 2);
        for (int k = 0; k < 4; k++) begin
            run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                   1'b0, 1'b0, $urandom_range(0, 3));
        end
        run_op(24'h000000, 24'hABCDEF, 1'b1, 1'b0, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        mif.multiplicand            = 24'd7;
        mif.multiplier              = 24'd9;
        mif.start_operation_mul_fsm = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(mif.busy), 64'(1));
        arst = 1'b1;
        #1;
        check("arst_product", 64'(mif.product), 64'(0));
        check("arst_done", 64'(mif.operation_done_mul_fsm), 64'(0));
        check("arst_busy", 64'(mif.busy), 64'(0));
        check("arst_state", 64'(dbg_state), 64'(0));
        mif.start_operation_mul_fsm = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        run_op(24'd7, 24'd9, 1'b0, 1'b0, 1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_seq_mul.md
Name: fpu_seq_mul

Overview:
- Sequential unsigned shift-and-add multiplier. It is the inverse-operation companion to the FPU's sequential restoring divider.
- It takes two WIDTH-bit mantissas and produces a 2*WIDTH-bit product, one multiplier bit per iteration.
- It uses the same level start/done handshake as the divider, so the FPU control FSM drives both units identically.

Parameters:
- WIDTH, 24, operand width in bits; product is 2*WIDTH bits. Legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  asynchronous reset, active-high.
- multiplicand  input  WIDTH  operand A, sampled on the edge entering mul_start_st.
- multiplier  input  WIDTH  operand B, sampled on the same edge as multiplicand.
- start_operation_mul_fsm  input  1  level request; one operation per high phase.
- product  output  2*WIDTH  registered result, A*B.
- operation_done_mul_fsm  output  1  registered; high while the FSM is in mul_result_valid_st.
- busy  output  1  registered; high in every state except mul_idle_st and mul_result_valid_st.

Behaviour:
- Reset (arst high, any time including mid-operation):
  - FSM goes to mul_idle_st.
  - product, operation_done_mul_fsm, busy, accumulator, multiplier shift register and counter all go to 0.
- Datapath registers:
  - acc: WIDTH+1 bits; the top bit is the carry.
  - mq: WIDTH bits, multiplier shift register.
  - mcand: WIDTH bits.
  - cnt: clog2(WIDTH+1) bits.
- States and transitions:
  - mul_idle_st: go to mul_start_st when start is high.
  - mul_start_st: load mcand = multiplicand, mq = multiplier, acc = 0, cnt = WIDTH. Go to mul_test_st.
  - mul_test_st: if mq[0] = 1 go to mul_add_st, else go to mul_shift_st.
  - mul_add_st: acc = acc[WIDTH-1:0] + mcand, with carry into acc[WIDTH]. Go to mul_shift_st.
  - mul_shift_st: {acc, mq} is logically shifted right by 1, with 0 entering the MSB. cnt = cnt - 1. Go to mul_check_counter_st.
  - mul_check_counter_st: if cnt = 0 go to mul_result_valid_st, else go to mul_test_st.
  - mul_result_valid_st: stay while start is high; go to mul_idle_st when start is low.
  - Any illegal encoding: go to mul_idle_st.
- Outputs:
  - product <= {acc[WIDTH-1:0], mq} on the edge entering mul_result_valid_st.
  - product holds that value until the next completion or reset. Idle, start and mid-operation states do not alter it.
  - operation_done_mul_fsm and busy are registered from the next state. They change on the same edge as the state register.
- Latency:
  - Counted from the edge that samples start high in idle to the edge that raises done: 2 + 3*WIDTH + popcount(multiplier) cycles.
  - For WIDTH=24: 74 + popcount.
  - Minimum is 74 (multiplier = 0); maximum is 98.
- Handshake:
  - Done stays high as long as start stays high.
  - Deasserting start returns the FSM to idle on the next edge, and done falls on that edge.
  - If start is already low when mul_result_valid_st is entered, done is a single-cycle pulse.
  - Start going low mid-operation is ignored; the operation completes.
  - A new operation needs start low for at least one cycle in idle, then high again. Start held high continuously never restarts the unit.
- Operands: changes to multiplicand/multiplier after the mul_start_st load have no effect on the running operation.
- Arithmetic: unsigned only; the product never overflows 2*WIDTH bits. Zero in either operand gives product 0 with normal latency.

Test Plan:
- Basic product and latency: A=3, B=5, start held high → done rises exactly 76 cycles after start sampled (74+2), product=0x00000000000F.
- Maximum operands: A=B=0xFFFFFF → done at 98 cycles, product=0xFFFFFE000001. busy is high for all 97 cycles in between.
- Zero operand and hold: A=0x123456, B=0 → product=0 at 74 cycles. Then A=0x800000, B=0x000002 → product=0x000001000000.
- Handshake:
  - Hold start 10 cycles past done → done stays high and product is stable for those 10 cycles; done falls one edge after start drops.
  - Start as a 1-cycle pulse → operation completes and done is a 1-cycle pulse.
  - Keep start high after done → no second operation starts.
- Operand isolation: change A/B to random values every cycle after the load edge → product equals the originally loaded A*B.
- Reset mid-operation: arst at cycle 30 of A=7, B=9 → all outputs 0 immediately (asynchronously). A new operation A=7, B=9 then yields 0x3F at 76 cycles.
